cam_match_encoder: RTL
======================

Name: cam_match_encoder

Overview:
- Downstream consumer of the CAM match stage. Accepts the DEPTH-bit match vector (one bit per storage slot, set = slot content equals search key) and streams out the binary index of every set bit, lowest index first, over a valid/ready interface.
- An all-zero vector produces a single miss record.
- Sits between the CAM array and the result/readout logic, turning a one-hot/multi-hot vector into a sequence of addresses.

Parameters:
- DEPTH, 16, number of CAM slots = width of match_vec.
- ADDR_W, 4, index width; must equal clog2(DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  global enable; low freezes all state.
- match_vec  in  DEPTH  match vector from CAM.
- match_valid  in  1  match_vec qualifier.
- match_ready  out  1  encoder can accept a vector.
- idx  out  ADDR_W  reported slot index.
- idx_valid  out  1  idx/idx_last/miss valid.
- idx_last  out  1  final record for the current vector.
- miss  out  1  record is a miss (vector was zero).
- idx_ready  in  1  downstream accepts record.
- busy  out  1  state != IDLE.

Behaviour:
- Reset is synchronous, active-low, on rst_n; clock is clk. Reset has priority over ena.
- Reset values: state=IDLE, pending=0, idx=0, idx_valid=0, idx_last=0, miss=0, busy=0. match_ready is 1 after reset whenever ena=1.
- match_ready = ena & (state==IDLE). It is combinational from registered state.
- States:
  - IDLE: accept when match_valid & match_ready. The vector is latched into pending.
    - Non-zero vector -> EMIT.
    - Zero vector -> MISS.
  - EMIT:
    - idx = index of lowest set bit of pending; idx_valid=1, miss=0.
    - idx_last=1 iff pending has exactly one bit set.
    - On idx_valid & idx_ready & ena: clear that bit. If idx_last, go to IDLE; otherwise stay in EMIT with the next lowest bit.
  - MISS: idx=0, idx_valid=1, miss=1, idx_last=1. On handshake -> IDLE.
- Latency and throughput:
  - A vector accepted in cycle N has its first record valid in cycle N+1.
  - One record per cycle when idx_ready is held high.
  - A vector with k set bits occupies EMIT for exactly k handshake cycles. The next vector can be accepted one cycle after the last handshake; no same-cycle accept.
- Outputs idx, idx_valid, idx_last and miss are registered. They stay stable while idx_valid=1 and idx_ready=0, per the AXI-style valid/ready rule: valid never drops without a handshake.
- ena=0: no state change, no handshake on either side (match_ready=0), outputs hold their values.
- match_valid while busy is ignored; upstream must hold it.
- Full vector (all DEPTH bits set): DEPTH records, indices 0..DEPTH-1; idx_last only on index DEPTH-1.
- Reset mid-stream: pending is discarded, any partial sequence is dropped, and the block returns to IDLE the next cycle.

Optional Feature:
- Macro CAM_MATCH_COUNT_EN.
- Defined: adds output hit_count[ADDR_W:0], the popcount of the accepted vector.
  - Registered at accept; value is 0 for a miss, DEPTH for an all-ones vector.
  - Holds until the next accept; reset value 0.
- Undefined: port and popcount logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cam_pkg:
  - CAM_DEPTH=16, CAM_ADDR_W=4.
  - State enum (IDLE, EMIT, MISS).
- Sub-module cam_prio_enc: combinational lowest-set-bit encoder producing index, one-hot mask of that bit, and "single bit remaining" flag. It is reused by the readout logic.

Test Plan:
- Reset, then match_vec=16'h0000 accepted -> one record: miss=1, idx=0, idx_last=1; busy returns to 0 after handshake.
- match_vec=16'h0010, idx_ready=1 -> idx=4, idx_last=1 at accept+1; match_ready=1 again at accept+2.
- match_vec=16'h8421, idx_ready=1 -> idx 0,5,10,15 on consecutive cycles; idx_last only with 15; hit_count=4 if CAM_MATCH_COUNT_EN.
- match_vec=16'h0006 with idx_ready low for 3 cycles -> idx=1 held stable; then 1 and 2 on consecutive handshakes.
- match_vec=16'hFFFF, drop ena for 2 cycles mid-stream -> sequence pauses with outputs held; all 16 indices eventually emitted in order.
- match_vec=16'h00F0, assert rst_n=0 after 2 records -> idx_valid=0 and state IDLE the next cycle; new vector 16'h0001 yields idx=0, idx_last=1.

Source files
------------

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared CAM geometry and match-encoder state codes
package cam_pkg;

  localparam int CAM_DEPTH  = 16;
  localparam int CAM_ADDR_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_MISS = 2'd2;

endpackage

// File: rtl/cam_prio_enc.sv
// rtl/cam_prio_enc.sv - lowest-set-bit encoder: index, one-hot mask, single-bit flag
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH,
  parameter int ADDR_W = CAM_ADDR_W
) (
  input  logic [DEPTH-1:0]  vec,
  output logic [ADDR_W-1:0] idx,
  output logic [DEPTH-1:0]  mask,
  output logic              single
);

  always_comb begin
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_W'(i);
    end
  end

  // Two's-complement isolates the lowest set bit; clearing it leaves zero iff one bit was set.
  assign mask   = vec & (~vec + DEPTH'(1));
  assign single = (vec != '0) && ((vec & (vec - DEPTH'(1))) == '0);

endmodule

// File: rtl/cam_match_encoder.sv
// rtl/cam_match_encoder.sv - streams indices of set match bits, lowest first
// Optional hit_count output enabled by CAM_MATCH_COUNT_EN.
module cam_match_encoder
  import cam_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH,
  parameter int ADDR_W = CAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DEPTH-1:0]  match_vec,
  input  logic              match_valid,
  output logic              match_ready,
  output logic [ADDR_W-1:0] idx,
  output logic              idx_valid,
  output logic              idx_last,
  output logic              miss,
  input  logic              idx_ready,
  output logic              busy
`ifdef CAM_MATCH_COUNT_EN
  ,
  output logic [ADDR_W:0]   hit_count
`endif
);

  logic [1:0]        state_q, state_d;
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [DEPTH-1:0]  mask_q, mask_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              idx_valid_q, idx_valid_d;
  logic              idx_last_q, idx_last_d;
  logic              miss_q, miss_d;

  logic [ADDR_W-1:0] enc_idx;
  logic [DEPTH-1:0]  enc_mask;
  logic              enc_single;
  logic              accept, hs, load;

  assign match_ready = ena & (state_q == ST_IDLE);
  assign accept      = match_valid & match_ready;
  assign hs          = ena & idx_valid_q & idx_ready;
  assign load        = (accept & (|match_vec))
                     | ((state_q == ST_EMIT) & hs & ~idx_last_q);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pending_d = match_vec;
          state_d   = (|match_vec) ? ST_EMIT : ST_MISS;
        end
      end
      ST_EMIT: begin
        if (hs) begin
          pending_d = pending_q & ~mask_q;
          if (idx_last_q) state_d = ST_IDLE;
        end
      end
      ST_MISS: begin
        if (hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Encoding the next pending vector lets every record leave straight from flops.
  cam_prio_enc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prio_enc (
    .vec    (pending_d),
    .idx    (enc_idx),
    .mask   (enc_mask),
    .single (enc_single)
  );

  always_comb begin
    idx_d       = idx_q;
    mask_d      = mask_q;
    idx_valid_d = idx_valid_q;
    idx_last_d  = idx_last_q;
    miss_d      = miss_q;
    if (load) begin
      idx_d       = enc_idx;
      mask_d      = enc_mask;
      idx_last_d  = enc_single;
      miss_d      = 1'b0;
      idx_valid_d = 1'b1;
    end else if (accept) begin
      idx_d       = '0;
      mask_d      = '0;
      idx_last_d  = 1'b1;
      miss_d      = 1'b1;
      idx_valid_d = 1'b1;
    end else if (hs & idx_last_q) begin
      idx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      mask_q      <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      idx_last_q  <= 1'b0;
      miss_q      <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      idx_last_q  <= idx_last_d;
      miss_q      <= miss_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign idx_last  = idx_last_q;
  assign miss      = miss_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef CAM_MATCH_COUNT_EN
  logic [ADDR_W:0] hit_count_q, hit_count_d;

  always_comb begin
    hit_count_d = hit_count_q;
    if (accept) begin
      hit_count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        hit_count_d = hit_count_d + (ADDR_W + 1)'(match_vec[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_q <= '0;
    end else if (ena) begin
      hit_count_q <= hit_count_d;
    end
  end

  assign hit_count = hit_count_q;
`endif

endmodule
